codec_intf: RTL and testbench

CODEC_INTF -- requirements
Module: codec_intf

---
 rtl/codec_intf.sv | 145 ++++++++++++++
 tb/tb_codec_intf.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/codec_intf.sv
// ---------------------------------------------------------------------------
// codec_intf: I2S-style serial interface to a stereo audio codec.
//
// An 11-bit free-running counter produces every codec clock and slot position:
// MCLK = clk/4, SCLK = clk/32, LRCLK = clk/2048 (0 = left slot, 1 = right slot).
// Each slot is 32 bit times. Bits 0..15 carry a 16-bit sample, MSB first.
// Bits 16..31 are zero padding.
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   synchronous active-low reset
//   SDin      in   serial ADC data from the codec, MSB first
//   left_tx   in   [15:0] left sample to transmit
//   right_tx  in   [15:0] right sample to transmit
//   MCLK      out  codec master clock (cnt[1])
//   SCLK      out  serial bit clock (cnt[4])
//   LRCLK     out  frame clock (cnt[10])
//   SDout     out  serial DAC data, MSB first
//   left_rx   out  [15:0] last complete left ADC sample
//   right_rx  out  [15:0] last complete right ADC sample
//   VALID     out  one-cycle strobe: left_rx/right_rx updated this cycle
//
// Build option
//   CODEC_LOOPBACK_EN  When defined, the RX path samples the internal SDout
//                      bit instead of the synchronized SDin. This gives a
//                      bit-exact loopback, and SDin is ignored.
// ---------------------------------------------------------------------------
module codec_intf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SDin,
    input  logic [15:0] left_tx,
    input  logic [15:0] right_tx,
    output logic        MCLK,
    output logic        SCLK,
    output logic        LRCLK,
    output logic        SDout,
    output logic [15:0] left_rx,
    output logic [15:0] right_rx,
    output logic        VALID
);

    localparam int unsigned CNT_W    = 11;
    localparam int unsigned SAMPLE_W = 16;

    // Counter values tested on the edge that leaves them
    localparam logic [CNT_W-1:0] CNT_FRAME_END = 11'h7FF;  // left TX load, prime
    localparam logic [CNT_W-1:0] CNT_LEFT_END  = 11'h3FF;  // right TX load
    localparam logic [CNT_W-1:0] CNT_RX_DONE   = 11'h5EF;  // right bit 15 captured

    logic [CNT_W-1:0]    r_cnt;
    logic                r_sync1;
    logic                r_sync2;
    logic [SAMPLE_W-1:0] r_left_sr;
    logic [SAMPLE_W-1:0] r_right_sr;
    logic [SAMPLE_W-1:0] r_tx_sr;
    logic [SAMPLE_W-1:0] r_left_rx;
    logic [SAMPLE_W-1:0] r_right_rx;
    logic                r_valid;
    logic                r_primed;

    logic                w_sclk_rise;
    logic                w_sclk_fall;
    logic                w_data_bit;
    logic                w_capture;
    logic                w_rx_bit;
    logic [SAMPLE_W-1:0] w_left_nxt;
    logic [SAMPLE_W-1:0] w_right_nxt;

    // SCLK edges happen on the clk edge that leaves these low-order counts
    assign w_sclk_rise = (r_cnt[4:0] == 5'b01111);
    assign w_sclk_fall = (r_cnt[4:0] == 5'b11111);
    // Slot bit index is cnt[9:5]. Indices below 16 have cnt[9] clear.
    assign w_data_bit  = ~r_cnt[9];
    assign w_capture   = w_sclk_rise & w_data_bit;

`ifdef CODEC_LOOPBACK_EN
    logic w_unused_sync;
    assign w_unused_sync = r_sync2;
    assign w_rx_bit      = r_tx_sr[SAMPLE_W-1];
`else
    assign w_rx_bit      = r_sync2;
`endif

    assign w_left_nxt  = {r_left_sr[SAMPLE_W-2:0], w_rx_bit};
    assign w_right_nxt = {r_right_sr[SAMPLE_W-2:0], w_rx_bit};

    // Counter, synchronizer, RX/TX shifters and sample hand-off
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_left_sr  <= '0;
            r_right_sr <= '0;
            r_tx_sr    <= '0;
            r_left_rx  <= '0;
            r_right_rx <= '0;
            r_valid    <= 1'b0;
            r_primed   <= 1'b0;
        end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
            r_sync1 <= SDin;
            r_sync2 <= r_sync1;

            if (w_capture && !r_cnt[10]) begin
                r_left_sr <= w_left_nxt;
            end
            if (w_capture && r_cnt[10]) begin
                r_right_sr <= w_right_nxt;
            end

            // The first full frame starts after the first wrap
            if (r_cnt == CNT_FRAME_END) begin
                r_primed <= 1'b1;
            end

            // Right bit 15 lands this same edge, so hand off its next value
            r_valid <= 1'b0;
            if ((r_cnt == CNT_RX_DONE) && r_primed) begin
                r_left_rx  <= r_left_sr;
                r_right_rx <= w_right_nxt;
                r_valid    <= 1'b1;
            end

            // Load has priority over the SCLK-fall shift that coincides with it
            if (r_cnt == CNT_FRAME_END) begin
                r_tx_sr <= left_tx;
            end else if (r_cnt == CNT_LEFT_END) begin
                r_tx_sr <= right_tx;
            end else if (w_sclk_fall) begin
                r_tx_sr <= {r_tx_sr[SAMPLE_W-2:0], 1'b0};
            end
        end
    end

    assign MCLK     = r_cnt[1];
    assign SCLK     = r_cnt[4];
    assign LRCLK    = r_cnt[10];
    assign SDout    = r_tx_sr[SAMPLE_W-1];
    assign left_rx  = r_left_rx;
    assign right_rx = r_right_rx;
    assign VALID    = r_valid;

endmodule

// File: tb/tb_codec_intf.sv
// ---------------------------------------------------------------------------
// tb_codec_intf: scoreboard bench for codec_intf.
// A stimulus process walks a table of frames. For each frame it drives the
// TX words and the codec ADC words, then queues the expected SDout slot words
// and the expected VALID events. Separate monitors pop these queues and
// compare them against the DUT outputs.
// Build option CODEC_LOOPBACK_EN is honoured: the expected RX words become
// the transmitted words.
// ---------------------------------------------------------------------------
module tb_codec_intf;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        SDin     = 1'b0;
    logic [15:0] left_tx  = 16'h0000;
    logic [15:0] right_tx = 16'h0000;
    logic        MCLK;
    logic        SCLK;
    logic        LRCLK;
    logic        SDout;
    logic [15:0] left_rx;
    logic [15:0] right_rx;
    logic        VALID;

    always #5 clk = ~clk;

    codec_intf dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SDin     (SDin),
        .left_tx  (left_tx),
        .right_tx (right_tx),
        .MCLK     (MCLK),
        .SCLK     (SCLK),
        .LRCLK    (LRCLK),
        .SDout    (SDout),
        .left_rx  (left_rx),
        .right_rx (right_rx),
        .VALID    (VALID)
    );

    int unsigned total = 0;
    int unsigned bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Reference position: clk edges since reset release
    int unsigned tb_k = 0;
    logic [10:0] tb_cnt;
    assign tb_cnt = tb_k[10:0];
    always @(posedge clk) begin
        if (!rst_n) tb_k <= 0;
        else        tb_k <= tb_k + 1;
    end

    // Codec model: each data bit is held for its whole 32-clk bit time
    logic [15:0] cod_l = 16'h0000;
    logic [15:0] cod_r = 16'h0000;
    int          cb;
    always @(negedge clk) begin
        cb = int'(tb_cnt[9:5]);
        if (cb < 16) SDin = tb_cnt[10] ? cod_r[15-cb] : cod_l[15-cb];
        else         SDin = 1'b0;
    end

    typedef struct { int unsigned k; logic [15:0] l; logic [15:0] r; } rx_exp_t;
    typedef struct { int unsigned slot; logic [15:0] w; } tx_exp_t;
    typedef struct { logic [15:0] l; logic [15:0] r; logic [15:0] cl; logic [15:0] cr; } frame_t;

    rx_exp_t rxq[$];
    tx_exp_t txq[$];
    frame_t  tbl[10];
    bit      chk_en = 1'b0;

    // Clock outputs, plus the first rising edges of SCLK and LRCLK
    int unsigned first_sclk  = 0;
    int unsigned first_lrclk = 0;
    bit          seen_sclk   = 1'b0;
    bit          seen_lrclk  = 1'b0;
    always @(negedge clk) begin
        if (chk_en)
            check("clocks{LR,S,M}", {29'd0, LRCLK, SCLK, MCLK},
                  {29'd0, tb_cnt[10], tb_cnt[4], tb_cnt[1]});
        if (!rst_n) begin
            seen_sclk   = 1'b0;
            seen_lrclk  = 1'b0;
            first_sclk  = 0;
            first_lrclk = 0;
        end else begin
            if (!seen_sclk && SCLK === 1'b1) begin
                seen_sclk  = 1'b1;
                first_sclk = tb_k;
            end
            if (!seen_lrclk && LRCLK === 1'b1) begin
                seen_lrclk  = 1'b1;
                first_lrclk = tb_k;
            end
        end
    end

    // VALID monitor
    rx_exp_t rx_e;
    always @(negedge clk) begin
        if (chk_en && VALID !== 1'b0) begin
            if (rxq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL valid_unexpected: VALID=%b at k=%0d, expected 0", VALID, tb_k);
            end else begin
                rx_e = rxq.pop_front();
                check("valid_k", tb_k, rx_e.k);
                check("left_rx", 32'(left_rx), 32'(rx_e.l));
                check("right_rx", 32'(right_rx), 32'(rx_e.r));
            end
        end
    end

    // SDout monitor: sample mid bit time, compare against the queued slot word
    int unsigned tx_slot;
    int          tx_bit;
    logic [15:0] tx_w;
    logic        tx_expb;
    always @(negedge clk) begin
        if (chk_en && rst_n && tb_cnt[4:0] == 5'd16 && txq.size() > 0) begin
            tx_slot = tb_k >> 10;
            tx_bit  = int'(tb_cnt[9:5]);
            if (txq[0].slot < tx_slot) begin
                total++;
                bad++;
                $display("FAIL sdout_stale: slot %0d never observed, now at slot %0d", txq[0].slot, tx_slot);
                void'(txq.pop_front());
            end else if (txq[0].slot == tx_slot) begin
                tx_w    = txq[0].w;
                tx_expb = (tx_bit < 16) ? tx_w[15-tx_bit] : 1'b0;
                check($sformatf("sdout_s%0d_b%0d", tx_slot, tx_bit), 32'(SDout), 32'(tx_expb));
                if (tx_bit == 31) void'(txq.pop_front());
            end
        end
    end

    task automatic wait_cnt(input logic [10:0] v);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tb_cnt != v && n < 4096);
        if (tb_cnt != v) begin
            total++;
            bad++;
            $display("FAIL wait_cnt: cnt=0x%0h, expected 0x%0h", tb_cnt, v);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_MCLK"},  32'(MCLK),     32'd0);
        check({tag, "_SCLK"},  32'(SCLK),     32'd0);
        check({tag, "_LRCLK"}, 32'(LRCLK),    32'd0);
        check({tag, "_SDout"}, 32'(SDout),    32'd0);
        check({tag, "_lrx"},   32'(left_rx),  32'd0);
        check({tag, "_rrx"},   32'(right_rx), 32'd0);
        check({tag, "_VALID"}, 32'(VALID),    32'd0);
    endtask

    // Frames base..base+n-1 complete. tbl[base+n] supplies the follow-on drive.
    task automatic run_epoch(input int unsigned base, input int unsigned n);
        logic [15:0] el;
        logic [15:0] er;
        right_tx = tbl[base].r;
        cod_l    = tbl[base].cl;
        cod_r    = tbl[base].cr;
        // Left slot of the first frame: TX register still holds its reset value
        txq.push_back('{0, 16'h0000});
        txq.push_back('{1, tbl[base].r});
        @(negedge clk);
        rst_n = 1'b1;
        for (int unsigned f = 0; f < n; f++) begin
            wait_cnt(11'h010);
            left_tx = tbl[base+f+1].l;
            wait_cnt(11'h500);
            right_tx = tbl[base+f+1].r;
            if (f < 2) begin
                check($sformatf("unprimed_lrx_f%0d", f), 32'(left_rx),  32'd0);
                check($sformatf("unprimed_rrx_f%0d", f), 32'(right_rx), 32'd0);
            end
            if (f == 0) begin
                check("sclk_first_rise", first_sclk, 32'd16);
                check("lrclk_first_rise", first_lrclk, 32'd1024);
            end
            wait_cnt(11'h700);
            cod_l = tbl[base+f+1].cl;
            cod_r = tbl[base+f+1].cr;
            if (f + 1 < n) begin
                txq.push_back('{2*(f+1),   tbl[base+f+1].l});
                txq.push_back('{2*(f+1)+1, tbl[base+f+1].r});
`ifdef CODEC_LOOPBACK_EN
                el = tbl[base+f+1].l;
                er = tbl[base+f+1].r;
`else
                el = tbl[base+f+1].cl;
                er = tbl[base+f+1].cr;
`endif
                rxq.push_back('{2048*(f+1) + 32'h5F0, el, er});
            end
        end
    endtask

    initial begin
        tbl[0] = '{16'h0000, 16'h7FFE, 16'hA5C3, 16'h1234};
        tbl[1] = '{16'h8001, 16'h7FFE, 16'hA5C3, 16'h1234};
        tbl[2] = '{16'h1111, 16'h0000, 16'hA5C3, 16'h1234};
        tbl[3] = '{16'h2222, 16'hFFFF, 16'h0001, 16'h8000};
        tbl[4] = '{16'hBEEF, 16'h0F0F, 16'hFFFF, 16'h8001};
        tbl[5] = '{16'h3C3C, 16'hC3C3, 16'h0000, 16'h0000};
        tbl[6] = '{16'h0000, 16'h1234, 16'hC0DE, 16'hCAFE};
        tbl[7] = '{16'h5A5A, 16'hA5A5, 16'hC0DE, 16'hCAFE};
        tbl[8] = '{16'h0F0F, 16'hF0F0, 16'h7FFF, 16'h0001};
        tbl[9] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};

        rst_n = 1'b0;
        repeat (10) @(negedge clk);
        check_all_zero("reset");
        chk_en = 1'b1;

        run_epoch(0, 5);

        // Reset in the middle of the left slot
        wait_cnt(11'h300);
        check("pre_reset_lrx_nonzero", 32'(left_rx != 16'h0000), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("midreset");
        repeat (4) @(negedge clk);

        run_epoch(6, 3);

        wait_cnt(11'h010);
        check("rx_queue_drained", rxq.size(), 32'd0);
        check("tx_queue_drained", txq.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog");
    end

endmodule
